unidad_de_busqueda: RTL

//  Instruction-fetch (requester) side of the synchronous instruction ROM. Owns the PC, drives
//  the ROM word address, absorbs the ROM's 1-cycle read latency, and loads the IF/ID register.

---
 rtl/unidad_de_busqueda_pkg.sv | 17 +
 rtl/unidad_de_busqueda_if.sv | 44 ++++
 rtl/unidad_de_busqueda_registro_if_id.sv | 47 ++++
 rtl/unidad_de_busqueda.sv | 102 ++++++++++
 4 files changed

// File: rtl/unidad_de_busqueda_pkg.sv
// Shared fetch-stage definitions: default widths, J/HLT encodings and the fetch state type.
package paquete_pipeline;
    localparam int unsigned ANCHO_DIR_DEF   = 10;
    localparam int unsigned ANCHO_INSTR_DEF = 32;
    localparam logic [5:0]  OPCODE_J        = 6'b000010;
    localparam logic [31:0] INSTR_HLT       = 32'h0000_0000;

    typedef enum logic [1:0] {
        ARRANQUE,
        CORRIENDO,
        DETENIDO
    } estado_t;

    function automatic logic es_salto_j(input logic [31:0] instr);
        return instr[31:26] == OPCODE_J;
    endfunction
endpackage

// File: rtl/unidad_de_busqueda_if.sv
// Fetch-stage bus: ROM address/data, HDU/SCU controls and the IF/ID outputs.
interface unidad_de_busqueda_if
    import paquete_pipeline::*;
#(
    parameter int unsigned ANCHO_DIR   = ANCHO_DIR_DEF,
    parameter int unsigned ANCHO_INSTR = ANCHO_INSTR_DEF
);
    logic [ANCHO_DIR-1:0]   direccion;
    logic [ANCHO_INSTR-1:0] instruccion;
    logic                   stall;
    logic                   redirect;
    logic [ANCHO_DIR-1:0]   destino;
    logic [ANCHO_INSTR-1:0] instruccion_id;
    logic [ANCHO_DIR-1:0]   pc_id;
    logic                   valido_id;
    logic                   salto_resuelto_id;
    logic                   detenido;

    modport master (
        output direccion,
        input  instruccion,
        input  stall,
        input  redirect,
        input  destino,
        output instruccion_id,
        output pc_id,
        output valido_id,
        output salto_resuelto_id,
        output detenido
    );

    modport slave (
        input  direccion,
        output instruccion,
        output stall,
        output redirect,
        output destino,
        input  instruccion_id,
        input  pc_id,
        input  valido_id,
        input  salto_resuelto_id,
        input  detenido
    );
endinterface

// File: rtl/unidad_de_busqueda_registro_if_id.sv
// IF/ID pipeline register: load-enable, synchronous bubble clear, async active-low reset.
module registro_if_id #(
    parameter int unsigned ANCHO_DIR   = 10,
    parameter int unsigned ANCHO_INSTR = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cargar_i,
    input  logic                   limpiar_i,
    input  logic [ANCHO_INSTR-1:0] instr_i,
    input  logic [ANCHO_DIR-1:0]   pc_i,
    input  logic                   valido_i,
    input  logic                   salto_i,
    output logic [ANCHO_INSTR-1:0] instr_o,
    output logic [ANCHO_DIR-1:0]   pc_o,
    output logic                   valido_o,
    output logic                   salto_o
);
    logic [ANCHO_INSTR-1:0] instr_q;
    logic [ANCHO_DIR-1:0]   pc_q;
    logic                   valido_q;
    logic                   salto_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q  <= '0;
            pc_q     <= '0;
            valido_q <= 1'b0;
            salto_q  <= 1'b0;
        end else if (limpiar_i) begin
            instr_q  <= '0;
            pc_q     <= '0;
            valido_q <= 1'b0;
            salto_q  <= 1'b0;
        end else if (cargar_i) begin
            instr_q  <= instr_i;
            pc_q     <= pc_i;
            valido_q <= valido_i;
            salto_q  <= salto_i;
        end
    end

    assign instr_o  = instr_q;
    assign pc_o     = pc_q;
    assign valido_o = valido_q;
    assign salto_o  = salto_q;
endmodule

// File: rtl/unidad_de_busqueda.sv
// Instruction fetch: PC, ROM addressing with 1-cycle latency tracking, stall/redirect/HLT handling.
// Optional early J resolution in fetch when FETCH_SALTO_TEMPRANO_EN is defined.
module unidad_de_busqueda
    import paquete_pipeline::*;
#(
    parameter int unsigned          ANCHO_DIR   = ANCHO_DIR_DEF,
    parameter int unsigned          ANCHO_INSTR = ANCHO_INSTR_DEF,
    parameter logic [ANCHO_DIR-1:0] PC_INICIAL  = '0
) (
    input logic                 clk,
    input logic                 rst_n,
    unidad_de_busqueda_if.master bus
);
    estado_t              estado_q, estado_d;
    logic [ANCHO_DIR-1:0] pc_q, pc_d;
    logic [ANCHO_DIR-1:0] vuelo_pc_q, vuelo_pc_d;
    logic                 vuelo_valido_q, vuelo_valido_d;
    logic                 cargar, limpiar, salto_d;
    logic [ANCHO_DIR-1:0] pc_id_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q       <= ARRANQUE;
            pc_q           <= PC_INICIAL;
            vuelo_pc_q     <= '0;
            vuelo_valido_q <= 1'b0;
        end else begin
            estado_q       <= estado_d;
            pc_q           <= pc_d;
            vuelo_pc_q     <= vuelo_pc_d;
            vuelo_valido_q <= vuelo_valido_d;
        end
    end

    // Re-presenting the in-flight address during a stall keeps the ROM output steady.
    assign bus.direccion = (bus.stall && !bus.redirect) ? vuelo_pc_q : pc_q;
    assign bus.detenido  = (estado_q == DETENIDO);
    assign pc_id_d       = vuelo_pc_q + ANCHO_DIR'(1);

    always_comb begin
        estado_d       = estado_q;
        pc_d           = pc_q;
        vuelo_pc_d     = vuelo_pc_q;
        vuelo_valido_d = vuelo_valido_q;
        cargar         = 1'b0;
        limpiar        = 1'b0;
        salto_d        = 1'b0;
        if (bus.redirect) begin
            pc_d           = bus.destino;
            vuelo_valido_d = 1'b0;
            limpiar        = 1'b1;
            estado_d       = CORRIENDO;
        end else if (!bus.stall) begin
            case (estado_q)
                ARRANQUE: begin
                    vuelo_pc_d     = pc_q;
                    vuelo_valido_d = 1'b1;
                    pc_d           = pc_q + ANCHO_DIR'(1);
                    limpiar        = 1'b1;
                    estado_d       = CORRIENDO;
                end
                CORRIENDO: begin
                    cargar         = 1'b1;
                    vuelo_pc_d     = pc_q;
                    vuelo_valido_d = 1'b1;
                    pc_d           = pc_q + ANCHO_DIR'(1);
                    if (vuelo_valido_q && bus.instruccion == INSTR_HLT) begin
                        vuelo_valido_d = 1'b0;
                        estado_d       = DETENIDO;
                    end
`ifdef FETCH_SALTO_TEMPRANO_EN
                    else if (vuelo_valido_q && es_salto_j(bus.instruccion)) begin
                        pc_d           = bus.instruccion[ANCHO_DIR-1:0];
                        vuelo_valido_d = 1'b0;
                        salto_d        = 1'b1;
                    end
`endif
                end
                DETENIDO: limpiar = 1'b1;
                default:  estado_d = ARRANQUE;
            endcase
        end
    end

    registro_if_id #(
        .ANCHO_DIR   (ANCHO_DIR),
        .ANCHO_INSTR (ANCHO_INSTR)
    ) u_if_id (
        .clk       (clk),
        .rst_n     (rst_n),
        .cargar_i  (cargar),
        .limpiar_i (limpiar),
        .instr_i   (bus.instruccion),
        .pc_i      (pc_id_d),
        .valido_i  (vuelo_valido_q),
        .salto_i   (salto_d),
        .instr_o   (bus.instruccion_id),
        .pc_o      (bus.pc_id),
        .valido_o  (bus.valido_id),
        .salto_o   (bus.salto_resuelto_id)
    );
endmodule
